// File: rtl/gpio_irq_pkg.sv
// Shared types for the GPIO interrupt generator: trigger-type encoding and
// the helper that turns per-pin inputs into a trigger according to its type.
package gpio_irq_pkg;

    localparam int unsigned IrqTypeW = 3;

    typedef enum logic [IrqTypeW-1:0] {
        IRQ_RISE       = 3'b000,
        IRQ_FALL       = 3'b001,
        IRQ_ANY_EDGE   = 3'b010,
        IRQ_LEVEL_HIGH = 3'b011,
        IRQ_LEVEL_LOW  = 3'b100
    } irq_type_e;

    // Reserved codes (101..111) never trigger.
    function automatic logic irq_trigger(
        input logic [IrqTypeW-1:0] typ,
        input logic                level,
        input logic                rise,
        input logic                fall
    );
        logic trig;
        case (irq_type_e'(typ))
            IRQ_RISE:       trig = rise;
            IRQ_FALL:       trig = fall;
            IRQ_ANY_EDGE:   trig = rise | fall;
            IRQ_LEVEL_HIGH: trig = level;
            IRQ_LEVEL_LOW:  trig = ~level;
            default:        trig = 1'b0;
        endcase
        return trig;
    endfunction

endpackage

// File: rtl/gpio_irq_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag; index is 0 when nothing
// is set.
module gpio_irq_prio_enc #(
    parameter int unsigned Width = 32,
    parameter int unsigned IdxW  = 5
) (
    input  logic [Width-1:0] req_i,
    output logic             valid_o,
    output logic [IdxW-1:0]  idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/gpio_irq_gen.sv
// GPIO interrupt generator: per-pin trigger selection, sticky pending status
// with write-1-to-clear and acknowledge-by-index, registered level interrupt
// and a one-cycle pulse on its rising edge.
module gpio_irq_gen
    import gpio_irq_pkg::*;
#(
    parameter int unsigned NrGpios  = 32,
    parameter int unsigned IdxWidth = (NrGpios > 1) ? $clog2(NrGpios) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrGpios-1:0]                serial_i,
    input  logic [NrGpios-1:0]                r_edge_i,
    input  logic [NrGpios-1:0]                f_edge_i,
    input  logic [NrGpios-1:0]                irq_en_i,
    input  logic [NrGpios-1:0][IrqTypeW-1:0]  irq_type_i,
    input  logic [NrGpios-1:0]                status_clr_i,
    output logic [NrGpios-1:0]                status_o,
    output logic                              irq_o,
    output logic                              irq_pulse_o,
    output logic                              pend_valid_o,
    output logic [IdxWidth-1:0]               pend_idx_o,
    input  logic                              pend_ack_i
);

    logic [NrGpios-1:0]  trig;
    logic [NrGpios-1:0]  ack_vec;
    logic [NrGpios-1:0]  status_d, status_q;
    logic                irq_d, irq_q;
    logic                pulse_d, pulse_q;
    logic                pend_valid;
    logic [IdxWidth-1:0] pend_idx;

    // Per-pin trigger, combinational from the strobes/levels and current type.
    always_comb begin
        trig = '0;
        for (int i = 0; i < NrGpios; i++) begin
            trig[i] = irq_trigger(irq_type_i[i], serial_i[i], r_edge_i[i], f_edge_i[i]);
        end
    end

    // One-hot clear for the acknowledged index; ignored when nothing is pending.
    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NrGpios; i++) begin
            ack_vec[i] = pend_ack_i & pend_valid & (pend_idx == IdxWidth'(i));
        end
    end

    // Next status: clears applied first, then sets OR'd in so a coincident
    // event is never lost (this also keeps level triggers re-asserting).
    always_comb begin
        status_d = (status_q & ~(status_clr_i | ack_vec)) | (irq_en_i & trig);
        irq_d    = |status_q;
        pulse_d  = irq_d & ~irq_q;
    end

    // Status, level interrupt and pulse registers; reset discards everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= '0;
            irq_q    <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= irq_d;
            pulse_q  <= pulse_d;
        end
    end

    gpio_irq_prio_enc #(
        .Width (NrGpios),
        .IdxW  (IdxWidth)
    ) u_prio_enc (
        .req_i   (status_q),
        .valid_o (pend_valid),
        .idx_o   (pend_idx)
    );

    assign status_o     = status_q;
    assign irq_o        = irq_q;
    assign irq_pulse_o  = pulse_q;
    assign pend_valid_o = pend_valid;
    assign pend_idx_o   = pend_idx;

endmodule

// File: doc/gpio_irq_gen.md
GPIO_IRQ_GEN -- requirements
Module: gpio_irq_gen

Interface
REQ-001 SHALL have parameter NrGpios, default 32: number of pins, legal range 1..64.
REQ-002 SHALL have parameter IdxWidth, default $clog2(NrGpios) with a minimum of 1: pending-index width.
REQ-003 SHALL have port clk_i  in  1  the single clock.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port serial_i  in  NrGpios  synchronised pin levels, one per input stage.
REQ-006 SHALL have port r_edge_i  in  NrGpios  rising-edge strobes, one per input stage.
REQ-007 SHALL have port f_edge_i  in  NrGpios  falling-edge strobes, one per input stage.
REQ-008 SHALL have port irq_en_i  in  NrGpios  per-pin interrupt enable.
REQ-009 SHALL have port irq_type_i  in  NrGpios x 3  per-pin trigger type.
REQ-010 SHALL have port status_clr_i  in  NrGpios  write-1-to-clear strobe from the register file.
REQ-011 SHALL have port status_o  out  NrGpios  sticky pending status.
REQ-012 SHALL have port irq_o  out  1  registered level interrupt.
REQ-013 SHALL have port irq_pulse_o  out  1  one-cycle pulse on each 0->1 transition of irq_o.
REQ-014 SHALL have port pend_valid_o  out  1  at least one status bit is set.
REQ-015 SHALL have port pend_idx_o  out  IdxWidth  lowest-numbered set status bit.
REQ-016 SHALL have port pend_ack_i  in  1  acknowledge: clears bit pend_idx_o.

Function
REQ-017 Trigger types SHALL be: 000 RISE, 001 FALL, 010 ANY_EDGE, 011 LEVEL_HIGH, 100 LEVEL_LOW; codes 101..111 SHALL never trigger.
REQ-018 The per-pin trigger SHALL be combinational from the inputs and the type: RISE uses r_edge_i, FALL uses f_edge_i, ANY_EDGE uses r_edge_i or f_edge_i, LEVEL_HIGH uses serial_i, LEVEL_LOW uses ~serial_i.
REQ-019 status[i] SHALL be set on the clock after a cycle in which irq_en_i[i] and trigger[i] are both 1.
REQ-020 status[i] SHALL clear on the clock after status_clr_i[i]=1, or after pend_ack_i=1 with pend_valid_o=1 and pend_idx_o=i.
REQ-021 When set and clear coincide on the same bit, set SHALL win, so no event is lost.
REQ-022 A level-type pin SHALL re-set its status every cycle while the level persists; a clear SHALL take effect only after the level is removed.
REQ-023 Deasserting irq_en_i[i] SHALL block new sets only; an existing status[i] SHALL remain until cleared.
REQ-024 Changing irq_type_i SHALL take effect in the same cycle and SHALL NOT alter status.
REQ-025 status_o SHALL be the status register, with no combinational path from the inputs.
REQ-026 irq_o SHALL be a flop equal to the OR of status, lagging status by one cycle.
REQ-027 irq_pulse_o SHALL be registered and equal irq_o & ~irq_o_prev.
REQ-028 A re-trigger while irq_o is already 1 SHALL NOT pulse.
REQ-029 pend_valid_o SHALL equal the OR of status_o, and pend_idx_o SHALL be the lowest set index; both SHALL be combinational from status.
REQ-030 pend_idx_o SHALL be 0 when pend_valid_o=0.
REQ-031 pend_ack_i SHALL be ignored while pend_valid_o=0.
REQ-032 Acknowledging one bit SHALL NOT affect any other bit.
REQ-033 After a clear, pend_idx_o SHALL advance to the next set bit on the following cycle.
REQ-034 Event-to-irq_o latency SHALL be 2 cycles.

Reset
REQ-035 Reset SHALL drive status_o=0, irq_o=0, irq_pulse_o=0 and the irq_o history flop to 0; hence pend_valid_o=0 and pend_idx_o=0.
REQ-036 Asserting reset mid-operation SHALL discard all pending status immediately, asynchronously.
REQ-037 No pulse SHALL be generated on reset release unless a new event occurs.

Structure
REQ-038 Package gpio_irq_pkg SHALL hold the irq_type_e enum (3-bit, codes as in REQ-017) and the type-field width constant.
REQ-039 The pending-index search SHALL use the single sub-module gpio_irq_prio_enc, a parameterised lowest-set-bit encoder with valid output.

Verification
REQ-040 Pin 3 RISE and enabled, r_edge_i[3] pulsed at cycle 0 -> status_o[3]=1 at cycle 1, irq_o=1 and irq_pulse_o=1 at cycle 2.
REQ-041 Pins 5 and 9 set; ack at pend_idx_o=5 -> next cycle pend_idx_o=9, still valid; ack again -> pend_valid_o=0 and irq_o=0 one cycle later.
REQ-042 Pin 0 LEVEL_HIGH with serial_i[0]=1 held 10 cycles and status_clr_i[0] pulsed at cycle 4 -> status stays 1; serial_i low then clear -> status 0.
REQ-043 FALL event on pin 7 in the same cycle as status_clr_i[7]=1 -> status_o[7]=1 next cycle.
REQ-044 Pin 2 disabled with ANY_EDGE strobes -> status stays 0; pin 2 set then disabled -> status holds 1 until cleared.
REQ-045 Pins 1 and 4 pending, rst_ni low mid-cycle -> all outputs 0 immediately; no irq_pulse_o after release.
